// File: rtl/line_pixel_timer_pkg.sv
// Shared horizontal/frame timing definitions for the line pixel timer and the
// downstream line counter.
package line_pixel_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int H_ACTIVE_DEF = 32;
  localparam int H_BLANK_DEF  = 4;
  localparam int FRAME_LINES  = 24;

endpackage

// File: rtl/line_pixel_timer_term_counter.sv
// Clear/increment counter with a terminal-count flag; clear wins over increment.
module term_counter #(
  parameter int W    = 5,
  parameter int TERM = 31
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_term = (cnt == W'(TERM));

endmodule

// File: rtl/line_pixel_timer.sv
// Horizontal pixel timer: walks each line through ACTIVE then BLANK, pulses
// newLine once per line and parks in DONE once the line counter reports endFrame.
module line_pixel_timer
  import line_pixel_timer_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_BLANK  = H_BLANK_DEF,
  parameter int COL_W    = 5,
  parameter int BLK_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             endFrame,
  output logic             newLine,
  output logic [COL_W-1:0] pix_col,
  output logic             pix_valid,
  output logic             hblank,
  output logic             frame_done
);

  state_t             state, state_nx;
  logic               stop, stop_nx;
  logic               col_inc, blk_inc;
  logic               col_term, blk_term, blk_pre;
  logic               line_nx;
  logic [COL_W-1:0]   col;
  logic [BLK_W-1:0]   blk;

  // Counters clear whenever they are not advancing, so col reads 0 outside ACTIVE.
  term_counter #(.W(COL_W), .TERM(H_ACTIVE-1)) u_col (
    .clk     (clk),
    .clr     (rst | ~col_inc),
    .inc     (col_inc),
    .cnt     (col),
    .at_term (col_term)
  );

  term_counter #(.W(BLK_W), .TERM(H_BLANK-1)) u_blk (
    .clk     (clk),
    .clr     (rst | ~blk_inc),
    .inc     (blk_inc),
    .cnt     (blk),
    .at_term (blk_term)
  );

  assign blk_pre = (blk == BLK_W'(H_BLANK-2));
  assign pix_col = col;

  always_comb begin
    state_nx = state;
    stop_nx  = stop;
    col_inc  = 1'b0;
    blk_inc  = 1'b0;
    line_nx  = 1'b0;
    if (!enb) begin
      state_nx = IDLE;
      stop_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: state_nx = ACTIVE;
        ACTIVE: begin
          if (endFrame) stop_nx = 1'b1;
          if (col_term) state_nx = BLANK;
          else          col_inc  = 1'b1;
        end
        BLANK: begin
          // endFrame seen on the edge that opens the last blank cycle still suppresses newLine.
          if (endFrame) stop_nx = 1'b1;
          if (blk_term) begin
            state_nx = stop_nx ? DONE : ACTIVE;
          end else begin
            blk_inc = 1'b1;
            line_nx = blk_pre & ~stop_nx;
          end
        end
        DONE: state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stop       <= 1'b0;
      newLine    <= 1'b0;
      pix_valid  <= 1'b0;
      hblank     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      stop       <= stop_nx;
      newLine    <= line_nx;
      pix_valid  <= (state_nx == ACTIVE);
      hblank     <= (state_nx == BLANK);
      frame_done <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_line_pixel_timer.sv
// Scoreboard bench for line_pixel_timer: default instance plus a 4/2 sweep instance.
module tb_line_pixel_timer;
  import line_pixel_timer_pkg::*;

  typedef struct packed {
    logic       nl;
    logic       pv;
    logic [4:0] col;
    logic       hb;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enb, ef_force, use_lc, lc_clr, enb_b, ef_b;
  logic       end_frame;
  logic       new_line, pix_valid, hblank, frame_done;
  logic [4:0] pix_col;
  logic       nl_b, pv_b, hb_b, fd_b;
  logic [1:0] col_b;

  int    lc = 0;
  int    pulses = 0;
  int    errors = 0;
  int    checks = 0;
  string tname = "init";
  exp_t  qa[$];
  exp_t  qb[$];

  localparam exp_t Z      = '0;
  localparam exp_t DONE_E = '{nl: 1'b0, pv: 1'b0, col: 5'd0, hb: 1'b0, fd: 1'b1};

  assign end_frame = ef_force | (use_lc && lc == FRAME_LINES);

  line_pixel_timer dut_a (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .endFrame   (end_frame),
    .newLine    (new_line),
    .pix_col    (pix_col),
    .pix_valid  (pix_valid),
    .hblank     (hblank),
    .frame_done (frame_done)
  );

  line_pixel_timer #(.H_ACTIVE(4), .H_BLANK(2), .COL_W(2), .BLK_W(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb_b),
    .endFrame   (ef_b),
    .newLine    (nl_b),
    .pix_col    (col_b),
    .pix_valid  (pv_b),
    .hblank     (hb_b),
    .frame_done (fd_b)
  );

  // Downstream line counter model and pulse tally.
  always @(posedge clk) begin
    if (lc_clr) lc <= 0;
    else if (new_line) lc <= lc + 1;
    if (new_line) pulses <= pulses + 1;
  end

  always @(posedge clk) begin
    exp_t e, g;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      g = {new_line, pix_valid, pix_col, hblank, frame_done};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s t=%0t: got nl=%b pv=%b col=%0d hb=%b fd=%b, expected nl=%b pv=%b col=%0d hb=%b fd=%b",
                 tname, $time, g.nl, g.pv, g.col, g.hb, g.fd, e.nl, e.pv, e.col, e.hb, e.fd);
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      g = {nl_b, pv_b, 3'b000, col_b, hb_b, fd_b};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s t=%0t: got nl=%b pv=%b col=%0d hb=%b fd=%b, expected nl=%b pv=%b col=%0d hb=%b fd=%b",
                 tname, $time, g.nl, g.pv, g.col, g.hb, g.fd, e.nl, e.pv, e.col, e.hb, e.fd);
      end
    end
  end

  function automatic exp_t line_exp(input int n, input int ha, input int hb);
    exp_t e;
    int   p;
    e = '0;
    p = n % (ha + hb);
    if (p < ha) begin
      e.pv  = 1'b1;
      e.col = 5'(p);
    end else begin
      e.hb = 1'b1;
    end
    if (p == ha + hb - 1) e.nl = 1'b1;
    return e;
  endfunction

  task automatic cyc(input logic r, input logic en, input logic ef, input exp_t e);
    rst = r; enb = en; ef_force = ef;
    qa.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic en, input exp_t e);
    rst = 1'b0; enb_b = en;
    qb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tname = "reset";
    cyc(1'b1, 1'b0, 1'b0, Z);
    cyc(1'b1, 1'b1, 1'b1, Z);
    lc_clr = 1'b0;
  endtask

  task automatic test_reset_in_run();
    tname = "reset_in_run";
    for (int n = 0; n <= 10; n++) cyc(1'b0, 1'b1, 1'b0, line_exp(n, 32, 4));
    cyc(1'b1, 1'b1, 1'b0, Z);
    for (int n = 0; n <= 5; n++) cyc(1'b0, 1'b1, 1'b0, line_exp(n, 32, 4));
    tname = "rst_glitch";
    rst = 1'b0; enb = 1'b1; ef_force = 1'b0;
    qa.push_back(line_exp(6, 32, 4));
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int n = 7; n <= 8; n++) cyc(1'b0, 1'b1, 1'b0, line_exp(n, 32, 4));
    cyc(1'b0, 1'b0, 1'b0, Z);
  endtask

  task automatic test_basic_line();
    int p0;
    tname = "basic_line";
    p0 = pulses;
    for (int n = 0; n < 360; n++) cyc(1'b0, 1'b1, 1'b0, line_exp(n, 32, 4));
    cyc(1'b0, 1'b0, 1'b0, Z);
    checks++;
    if (pulses - p0 !== 10) begin
      errors++;
      $display("FAIL basic_pulse_count: got %0d, expected 10", pulses - p0);
    end
  endtask

  task automatic test_integration();
    exp_t e;
    tname = "integration";
    lc_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, Z);
    lc_clr = 1'b0;
    use_lc = 1'b1;
    for (int n = 0; n < 920; n++) begin
      e = (n >= 25 * 36) ? DONE_E : line_exp(n, 32, 4);
      if (n >= 24 * 36 && n < 25 * 36) e.nl = 1'b0;
      cyc(1'b0, 1'b1, 1'b0, e);
    end
    checks++;
    if (lc !== FRAME_LINES) begin
      errors++;
      $display("FAIL integration_line_count: got %0d, expected %0d", lc, FRAME_LINES);
    end
    cyc(1'b0, 1'b0, 1'b0, Z);
    use_lc = 1'b0;
  endtask

  task automatic test_late_endframe();
    int p0;
    tname = "late_endframe";
    p0 = pulses;
    for (int n = 0; n <= 35; n++) cyc(1'b0, 1'b1, 1'b0, line_exp(n, 32, 4));
    cyc(1'b0, 1'b1, 1'b1, DONE_E);
    for (int n = 0; n < 10; n++) cyc(1'b0, 1'b1, 1'b0, DONE_E);
    cyc(1'b0, 1'b0, 1'b0, Z);
    checks++;
    if (pulses - p0 !== 1) begin
      errors++;
      $display("FAIL late_pulse_count: got %0d, expected 1", pulses - p0);
    end
  endtask

  task automatic test_enable_drop();
    exp_t e;
    int   p0;
    tname = "enable_drop";
    p0 = pulses;
    for (int n = 0; n <= 33; n++) cyc(1'b0, 1'b1, 1'b0, line_exp(n, 32, 4));
    cyc(1'b0, 1'b0, 1'b0, Z);
    checks++;
    if (pulses - p0 !== 0) begin
      errors++;
      $display("FAIL drop_no_pulse: got %0d, expected 0", pulses - p0);
    end
    tname = "enable_restart";
    for (int n = 0; n <= 36; n++) cyc(1'b0, 1'b1, 1'b0, line_exp(n, 32, 4));
    cyc(1'b0, 1'b0, 1'b0, Z);
    tname = "done_restart";
    cyc(1'b0, 1'b1, 1'b0, line_exp(0, 32, 4));
    cyc(1'b0, 1'b1, 1'b1, line_exp(1, 32, 4));
    for (int n = 2; n <= 35; n++) begin
      e = line_exp(n, 32, 4);
      e.nl = 1'b0;
      cyc(1'b0, 1'b1, 1'b0, e);
    end
    for (int n = 36; n <= 39; n++) cyc(1'b0, 1'b1, 1'b0, DONE_E);
    cyc(1'b0, 1'b0, 1'b0, Z);
    for (int n = 0; n <= 36; n++) cyc(1'b0, 1'b1, 1'b0, line_exp(n, 32, 4));
    cyc(1'b0, 1'b0, 1'b0, Z);
  endtask

  task automatic test_param_sweep();
    tname = "param_sweep";
    for (int n = 0; n < 24; n++) cyc_b(1'b1, line_exp(n, 4, 2));
    cyc_b(1'b0, Z);
  endtask

  initial begin
    rst = 1'b1; enb = 1'b0; ef_force = 1'b0; use_lc = 1'b0;
    lc_clr = 1'b1; enb_b = 1'b0; ef_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_reset_in_run();
    test_basic_line();
    test_integration();
    test_late_endframe();
    test_enable_drop();
    test_param_sweep();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_pixel_timer.md
Name: line_pixel_timer

Overview:
- Horizontal timing stage that sits directly upstream of the 24-line frame counter.
- Counts pixel clocks within each line (active pixels, then horizontal blanking) and issues the one-cycle `newLine` pulse that the line counter increments on.
- Consumes the line counter's `endFrame` to stop line generation at the end of a frame.
- Also drives the pixel column index and the valid/blank qualifiers used by the pattern datapath.

Parameters:
- H_ACTIVE, 32, active pixels per line (must be ≥ 2).
- H_BLANK, 4, blanking cycles per line (must be ≥ 2).
- COL_W, 5, width of pix_col; must satisfy 2^COL_W ≥ H_ACTIVE.
- BLK_W, 3, width of the internal blank counter; must satisfy 2^BLK_W ≥ H_BLANK.

Ports:
- clk  input  1  master clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enb  input  1  active-high run enable.
- endFrame  input  1  from the downstream line counter; high once 24 lines are done.
- newLine  output  1  registered one-cycle pulse, once per completed line.
- pix_col  output  COL_W  current active column, 0..H_ACTIVE-1; 0 outside ACTIVE.
- pix_valid  output  1  high during active pixels.
- hblank  output  1  high during blanking cycles.
- frame_done  output  1  high while in DONE.

Interface (already decided): one clock, `clk`; reset `rst` is synchronous and active-high. `rst` sampled high at a posedge puts the block in reset; there is no asynchronous path.

Behaviour:
- All outputs are registered.
- **Reset:** `rst`=1 at a posedge → state IDLE, col=0, blk=0, stop=0. All outputs read 0 in the following cycle. `rst` overrides every other input.
- **States:** IDLE, ACTIVE, BLANK, DONE.
- **Enable priority:** `enb`=0 at any posedge (and `rst`=0) → next state IDLE, counters cleared, stop cleared, all outputs 0. This applies in every state, including mid-line and DONE.
- **IDLE:** if `enb`=1 → ACTIVE with col=0. Outputs in that first cycle: pix_valid=1, pix_col=0.
- **ACTIVE:**
  - col increments by 1 each cycle.
  - When col == H_ACTIVE-1 → BLANK with blk=0, pix_valid=0, hblank=1.
  - pix_col never exceeds H_ACTIVE-1; there is no wrap inside ACTIVE.
- **BLANK:**
  - blk increments by 1 each cycle.
  - When blk == H_BLANK-2 at a posedge, the next cycle is the last blank cycle, and newLine=1 in that cycle if stop=0.
  - When blk == H_BLANK-1 → ACTIVE with col=0 if stop=0, otherwise DONE.
- **Line period:** exactly H_ACTIVE+H_BLANK cycles. newLine is high for exactly one cycle per line, in the last blank cycle.
- **Stop flag:**
  - Set at any posedge where `endFrame`=1 in ACTIVE or BLANK.
  - If stop is set before the last blank cycle begins, that line's newLine is suppressed. The downstream count therefore stays at 24 and is not pushed to 25.
  - If `endFrame` is first sampled during the last blank cycle (newLine already high), the pulse is not retracted; the block still goes to DONE.
- **DONE:**
  - frame_done=1; pix_valid=0, hblank=0, newLine=0.
  - Holds until `enb`=0 (→ IDLE).
  - `endFrame` is ignored in DONE.
- **Simultaneous events:** priority is `rst` > `enb`=0 > `endFrame` > normal count.
- **Arithmetic:** counters are unsigned. col is COL_W bits; blk is BLK_W bits. Terminal comparisons use `==` on parameter-1 values.

Decomposition:
- Shared timing package holds:
  - state encoding constants: IDLE=2'd0, ACTIVE=2'd1, BLANK=2'd2, DONE=2'd3;
  - default H_ACTIVE, H_BLANK and frame line count 24, shared with the line counter.
- One natural sub-module, `term_counter`: a parameterised clear/increment counter with a terminal-count flag. Instantiate it twice, for col and blk.
- The FSM, stop flag and output registers stay in the top module.

Test Plan:
- **Reset in run:** `rst`=1 mid-ACTIVE at col=10 → next cycle newLine=0, pix_valid=0, hblank=0, frame_done=0, pix_col=0. Confirm reset is synchronous: `rst` pulsed between edges has no effect.
- **Basic line (defaults):** `enb` rises, first ACTIVE cycle = cycle 0 →
  - pix_valid=1 with pix_col 0..31 over cycles 0..31;
  - hblank=1 over cycles 32..35;
  - newLine=1 only in cycle 35;
  - pix_col=0 and pix_valid=1 again at cycle 36;
  - exactly 10 newLine pulses in 360 cycles.
- **Integration with line counter:**
  - After the 24th newLine, endFrame=1 during line 25 → no 25th newLine.
  - frame_done=1 from cycle 25×36 onward; downstream count holds at 24.
- **Late endFrame:** force `endFrame` high only in the last blank cycle of a line → that line's newLine still fires once, then DONE next cycle, no further pulses.
- **Enable drop:**
  - `enb`=0 at BLANK blk=1 → IDLE, no newLine.
  - `enb`=1 again → fresh line from col=0; first newLine 35 cycles later.
  - From DONE, `enb` toggle 0→1 restarts the sequence.
- **Parameter sweep:** H_ACTIVE=4, H_BLANK=2 → newLine period 6 cycles, pix_col 0..3, hblank 2 cycles.
